// File: rtl/javk_bus_unit_pkg.sv
// Shared JAVK bus definitions: state encodings, rw strobe levels and default bus widths.
package javk_bus_unit_pkg;

  localparam int unsigned JAVK_ADDR_W = 16;
  localparam int unsigned JAVK_DATA_W = 8;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_WAIT  = 3'd2,
    ST_XFER  = 3'd3,
    ST_DONE  = 3'd4
  } bus_state_e;

  // Width of a beat index / req_len field, never below one bit.
  function automatic int unsigned javk_len_w(input int unsigned max_bytes);
    return (max_bytes > 1) ? $clog2(max_bytes) : 1;
  endfunction

endpackage

// File: rtl/javk_byte_lane.sv
// Byte-lane mux/demux: picks the write byte for a beat and merges a read byte into its lane.
module javk_byte_lane #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BYTES = 2,
  parameter int unsigned IDX_W     = 1
) (
  input  logic [MAX_BYTES*DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]            wsel,
  output logic [DATA_W-1:0]           wbyte_c,
  input  logic [MAX_BYTES*DATA_W-1:0] rdata,
  input  logic [IDX_W-1:0]            rsel,
  input  logic [DATA_W-1:0]           rbyte,
  output logic [MAX_BYTES*DATA_W-1:0] rdata_c
);

  always_comb begin
    wbyte_c = '0;
    rdata_c = rdata;
    for (int unsigned k = 0; k < MAX_BYTES; k++) begin
      if (wsel == IDX_W'(k)) wbyte_c = wdata[k*DATA_W +: DATA_W];
      if (rsel == IDX_W'(k)) rdata_c[k*DATA_W +: DATA_W] = rbyte;
    end
  end

endmodule

// File: rtl/javk_bus_unit.sv
// javk_bus_unit: serialises multi-byte core requests onto the JAVK external bus with wait states.
// Define JAVK_BUS_READY_EN to add a bus_ready input that can stretch each XFER cycle.
module javk_bus_unit
  import javk_bus_unit_pkg::*;
#(
  parameter int unsigned ADDR_W      = JAVK_ADDR_W,
  parameter int unsigned DATA_W      = JAVK_DATA_W,
  parameter int unsigned MAX_BYTES   = 2,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned LEN_W       = javk_len_w(MAX_BYTES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [LEN_W-1:0]            req_len,
  input  logic [MAX_BYTES*DATA_W-1:0] req_wdata,
  output logic                        rsp_valid,
  output logic [MAX_BYTES*DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0]           addrbus,
  output logic                        rw,
  inout  wire  [DATA_W-1:0]           databus
`ifdef JAVK_BUS_READY_EN
  ,
  input  logic                        bus_ready
`endif
);

  localparam int unsigned WCNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam logic [WCNT_W-1:0] WAIT_INIT = (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;
  localparam logic [LEN_W-1:0]  LAST_MAX  = LEN_W'(MAX_BYTES - 1);
  localparam int unsigned WORD_W = MAX_BYTES * DATA_W;

  bus_state_e         state_q, state_d;
  logic [LEN_W-1:0]   beat_q, beat_d, last_q, last_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  base_q, base_d, addr_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d, rdata_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic               rw_d, drv_q, drv_d, ready_d, rsp_d;
  logic [DATA_W-1:0]  dout_q, dout_d;

  logic [LEN_W-1:0]   nbeat_c, last_c;
  logic [WORD_W-1:0]  wsrc_c, lane_rdata_c;
  logic [DATA_W-1:0]  lane_wbyte_c;
  logic               xfer_go_c;

`ifdef JAVK_BUS_READY_EN
  assign xfer_go_c = bus_ready;
`else
  assign xfer_go_c = 1'b1;
`endif

  // Beat index and write-data source for the beat whose SETUP starts on the next edge.
  assign nbeat_c = (state_q == ST_IDLE) ? '0 : beat_q + LEN_W'(1);
  assign wsrc_c  = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign last_c  = (req_len > LAST_MAX) ? LAST_MAX : req_len;

  assign databus = drv_q ? dout_q : {DATA_W{1'bz}};

  javk_byte_lane #(
    .DATA_W   (DATA_W),
    .MAX_BYTES(MAX_BYTES),
    .IDX_W    (LEN_W)
  ) u_lane (
    .wdata  (wsrc_c),
    .wsel   (nbeat_c),
    .wbyte_c(lane_wbyte_c),
    .rdata  (rsp_rdata),
    .rsel   (beat_q),
    .rbyte  (databus),
    .rdata_c(lane_rdata_c)
  );

  // Next state plus the registered bus/handshake values for the coming cycle.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    last_d  = last_q;
    wr_d    = wr_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    wcnt_d  = wcnt_q;
    addr_d  = addrbus;
    rw_d    = rw;
    drv_d   = drv_q;
    dout_d  = dout_q;
    rdata_d = rsp_rdata;
    ready_d = 1'b0;
    rsp_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          base_d  = req_addr;
          last_d  = last_c;
          wdata_d = req_wdata;
          beat_d  = '0;
          rdata_d = '0;
          addr_d  = req_addr;
          rw_d    = req_write ? RW_WRITE : RW_READ;
          drv_d   = req_write;
          dout_d  = lane_wbyte_c;
          state_d = ST_SETUP;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_SETUP: begin
        wcnt_d  = WAIT_INIT;
        state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_XFER;
      end
      ST_WAIT: begin
        if (wcnt_q == '0) state_d = ST_XFER;
        else              wcnt_d  = wcnt_q - WCNT_W'(1);
      end
      ST_XFER: begin
        if (xfer_go_c) begin
          if (!wr_q) rdata_d = lane_rdata_c;
          if (beat_q == last_q) begin
            rsp_d   = 1'b1;
            rw_d    = RW_READ;
            drv_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            beat_d  = nbeat_c;
            addr_d  = base_q + ADDR_W'(nbeat_c);
            rw_d    = wr_q ? RW_WRITE : RW_READ;
            drv_d   = wr_q;
            dout_d  = lane_wbyte_c;
            state_d = ST_SETUP;
          end
        end
      end
      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        rw_d    = RW_READ;
        drv_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      beat_q    <= '0;
      last_q    <= '0;
      wr_q      <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      wcnt_q    <= '0;
      addrbus   <= '0;
      rw        <= RW_READ;
      drv_q     <= 1'b0;
      dout_q    <= '0;
      rsp_rdata <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      last_q    <= last_d;
      wr_q      <= wr_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      wcnt_q    <= wcnt_d;
      addrbus   <= addr_d;
      rw        <= rw_d;
      drv_q     <= drv_d;
      dout_q    <= dout_d;
      rsp_rdata <= rdata_d;
      req_ready <= ready_d;
      rsp_valid <= rsp_d;
    end
  end

endmodule
